// File: rtl/config_loader_pkg.sv
// Shared types and sizing helpers for the tile configuration loader.
// Holds the FSM state encoding and frame/counter width functions.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } state_t;

  function automatic int num_words(input int cw, input int ww);
    return (cw + ww - 1) / ww;
  endfunction

  // Bits needed to count 0 .. n+1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 2);
  endfunction

  localparam int CNT_WIDTH = cnt_width(num_words(524, 8));

endpackage

// File: rtl/config_loader.sv
// Tile configuration loader: assembles bitstream words in a shadow
// register and commits them atomically. Option: CONFIG_LOADER_CHECKSUM_EN.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CONFIG_WIDTH = 524,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    busy,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_done,
  output logic                    config_error
);

  localparam int NW    = num_words(CONFIG_WIDTH, WORD_WIDTH);
  localparam int CW    = cnt_width(NW);
  localparam int LASTW = CONFIG_WIDTH - (NW - 1) * WORD_WIDTH;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic [CONFIG_WIDTH-1:0] shadow_nxt;
  logic                    xfer;
  logic                    last_word;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0]   sum;
`else
  assign config_error = 1'b0;
`endif

  assign data_ready = (state == LOAD) || (state == CHECK);
  assign busy       = data_ready;
  assign xfer       = data_valid && data_ready;
  assign last_word  = (cnt == CW'(NW - 1));

  // Shadow image with the current word merged at its slot.
  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < NW - 1; k++) begin
      if (cnt == CW'(k))
        shadow_nxt[k*WORD_WIDTH +: WORD_WIDTH] = data_in;
    end
    if (last_word)
      shadow_nxt[CONFIG_WIDTH-1 -: LASTW] = data_in[LASTW-1:0];
  end

  // Frame FSM: start restarts, payload fills shadow, commit on completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      config_out  <= '0;
      config_done <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      sum          <= '0;
      config_error <= 1'b0;
`endif
    end else if (start) begin
      state       <= LOAD;
      cnt         <= '0;
      shadow      <= '0;
      config_done <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      sum          <= '0;
      config_error <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            shadow <= shadow_nxt;
            cnt    <= cnt + CW'(1);
`ifdef CONFIG_LOADER_CHECKSUM_EN
            sum    <= sum + data_in;
            if (last_word)
              state <= CHECK;
`else
            if (last_word) begin
              config_out  <= shadow_nxt;
              config_done <= 1'b1;
              state       <= DONE;
            end
`endif
          end
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            if (data_in == sum) begin
              config_out   <= shadow;
              config_done  <= 1'b1;
              config_error <= 1'b0;
              state        <= DONE;
            end else begin
              config_done  <= 1'b0;
              config_error <= 1'b1;
              state        <= IDLE;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: full loads, gaps, restart,
// reset mid-load, old config held, and the optional checksum.
module tb_config_loader;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic         busy;
  logic [523:0] config_out;
  logic         config_done;
  logic         config_error;

  int total = 0;
  int bad = 0;
  int ready_seen = 0;
  logic done_at_last = 1'b0;

  logic [523:0] exp_inc;
  logic [523:0] exp_5a;
  logic [523:0] exp_ff;
  logic [523:0] held;

  config_loader dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .busy(busy),
    .config_out(config_out),
    .config_done(config_done),
    .config_error(config_error)
  );

  always #5 clock = ~clock;

  // Called at a negedge; returns at the negedge after the pulse.
  task automatic pulse_start(input bit with_word);
    start = 1'b1;
    data_valid = with_word;
    data_in = 8'hFF;
    @(negedge clock);
    start = 1'b0;
    data_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the last transfer.
  task automatic send_words(input int n, input bit incr,
                            input logic [7:0] val, input bit gaps);
    int k = 0;
    int guard = 0;
    ready_seen = 0;
    while (k < n && guard < 4000) begin
      data_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      data_in = incr ? k[7:0] : val;
      if (data_ready) ready_seen++;
      if (data_valid && data_ready) begin
        k++;
        done_at_last = config_done;
      end
      guard++;
      @(negedge clock);
    end
    data_valid = 1'b0;
    total++;
    if (k != n) begin
      bad++;
      $display("FAIL send_timeout got=%0d words exp=%0d", k, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    total++;
    if (config_out !== '0) begin
      bad++; $display("FAIL rst_cfg got=%h exp=0", config_out);
    end
    total++;
    if ({config_done, config_error, busy, data_ready} !== 4'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=0000",
               {config_done, config_error, busy, data_ready});
    end
  endtask

  task automatic test_full();
    pulse_start(1'b0);
    send_words(66, 1'b1, 8'h00, 1'b0);
    total++;
    if (ready_seen != 66) begin
      bad++; $display("FAIL full_ready got=%0d exp=66", ready_seen);
    end
    total++;
    if (config_done !== 1'b1 || done_at_last !== 1'b0) begin
      bad++;
      $display("FAIL full_done got=%b/%b exp=0/1", done_at_last, config_done);
    end
    total++;
    if (config_out[7:0] !== 8'h00 || config_out[15:8] !== 8'h01) begin
      bad++; $display("FAIL full_lo got=%h exp=0100", config_out[15:0]);
    end
    total++;
    if (config_out[519:512] !== 8'h40 || config_out[523:520] !== 4'h1) begin
      bad++; $display("FAIL full_hi got=%h exp=140", config_out[523:512]);
    end
    total++;
    if (config_out !== exp_inc) begin
      bad++; $display("FAIL full_cfg got=%h exp=%h", config_out, exp_inc);
    end
    total++;
    if (busy !== 1'b0 || data_ready !== 1'b0) begin
      bad++; $display("FAIL full_busy got=%b%b exp=00", busy, data_ready);
    end
    data_valid = 1'b1;
    data_in = 8'hEE;
    repeat (3) @(negedge clock);
    data_valid = 1'b0;
    total++;
    if (config_out !== exp_inc || config_done !== 1'b1) begin
      bad++; $display("FAIL done_ignore got=%h exp=%h", config_out, exp_inc);
    end
  endtask

  task automatic test_gaps();
    pulse_start(1'b0);
    total++;
    if (config_done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL gap_start got=%b%b exp=01", config_done, busy);
    end
    send_words(66, 1'b1, 8'h00, 1'b1);
    total++;
    if (done_at_last !== 1'b0 || config_done !== 1'b1) begin
      bad++;
      $display("FAIL gap_done got=%b/%b exp=0/1", done_at_last, config_done);
    end
    total++;
    if (config_out !== exp_inc) begin
      bad++; $display("FAIL gap_cfg got=%h exp=%h", config_out, exp_inc);
    end
  endtask

  task automatic test_old_held();
    pulse_start(1'b0);
    send_words(20, 1'b0, 8'hFF, 1'b0);
    total++;
    if (config_out !== exp_inc || config_done !== 1'b0) begin
      bad++;
      $display("FAIL held_cfg got=%h done=%b exp=%h done=0",
               config_out, config_done, exp_inc);
    end
    send_words(46, 1'b0, 8'hFF, 1'b0);
    total++;
    if (config_out !== exp_ff || config_done !== 1'b1) begin
      bad++; $display("FAIL held_ff got=%h exp=%h", config_out, exp_ff);
    end
  endtask

  task automatic test_restart();
    pulse_start(1'b0);
    send_words(30, 1'b0, 8'hFF, 1'b0);
    pulse_start(1'b1);
    total++;
    if (config_out !== exp_ff || busy !== 1'b1) begin
      bad++; $display("FAIL rs_keep got=%h exp=%h", config_out, exp_ff);
    end
    send_words(66, 1'b0, 8'h5A, 1'b0);
    total++;
    if (config_out !== exp_5a || config_done !== 1'b1) begin
      bad++; $display("FAIL rs_cfg got=%h exp=%h", config_out, exp_5a);
    end
    total++;
    if (config_out[523:520] !== 4'hA) begin
      bad++; $display("FAIL rs_top got=%h exp=a", config_out[523:520]);
    end
  endtask

  task automatic test_reset_midload();
    pulse_start(1'b0);
    send_words(10, 1'b1, 8'h00, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++;
    if (config_out !== '0) begin
      bad++; $display("FAIL mid_cfg got=%h exp=0", config_out);
    end
    total++;
    if ({config_done, busy, data_ready} !== 3'b0) begin
      bad++;
      $display("FAIL mid_flags got=%b exp=000",
               {config_done, busy, data_ready});
    end
    data_valid = 1'b1;
    repeat (3) @(negedge clock);
    data_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || config_out !== '0) begin
      bad++; $display("FAIL idle_ignore got=%b exp=0", busy);
    end
  endtask

`ifdef CONFIG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start(1'b0);
    send_words(66, 1'b1, 8'h00, 1'b0);
    total++;
    if ({config_done, busy, data_ready} !== 3'b011) begin
      bad++;
      $display("FAIL ck_wait got=%b exp=011",
               {config_done, busy, data_ready});
    end
    send_words(1, 1'b0, 8'h61, 1'b0);
    total++;
    if (config_done !== 1'b1 || config_error !== 1'b0 ||
        config_out !== exp_inc) begin
      bad++;
      $display("FAIL ck_good got=%b%b %h exp=10 %h",
               config_done, config_error, config_out, exp_inc);
    end
    pulse_start(1'b0);
    send_words(66, 1'b0, 8'h5A, 1'b0);
    send_words(1, 1'b0, 8'h34, 1'b0);
    total++;
    if (config_done !== 1'b1 || config_out !== exp_5a) begin
      bad++; $display("FAIL ck_5a got=%h exp=%h", config_out, exp_5a);
    end
    pulse_start(1'b0);
    send_words(66, 1'b1, 8'h00, 1'b0);
    send_words(1, 1'b0, 8'h62, 1'b0);
    total++;
    if ({config_done, config_error, busy} !== 3'b010) begin
      bad++;
      $display("FAIL ck_bad got=%b exp=010",
               {config_done, config_error, busy});
    end
    total++;
    if (config_out !== exp_5a) begin
      bad++; $display("FAIL ck_keep got=%h exp=%h", config_out, exp_5a);
    end
    pulse_start(1'b0);
    total++;
    if (config_error !== 1'b0) begin
      bad++; $display("FAIL ck_clear got=%b exp=0", config_error);
    end
  endtask
`endif

  initial begin
    logic [527:0] w;
    for (int k = 0; k < 66; k++) w[k*8 +: 8] = k[7:0];
    exp_inc = w[523:0];
    w = {66{8'h5A}};
    exp_5a = w[523:0];
    exp_ff = '1;
    held = '0;

    @(negedge clock);
    test_reset();
`ifdef CONFIG_LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_full();
    test_gaps();
    test_old_held();
    test_restart();
    test_reset_midload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
